// File: rtl/vga_text_pkg.sv
// ---------------------------------------------------------------------------
// vga_text_pkg
// Shared constants and types for the hex text overlay:
//   - colour constants used by the renderer (12-bit {R4,G4,B4})
//   - text cell geometry (characters per cell, digits per cell, glyph size)
//   - column_t naming the three buffer columns (CPU, instruction, data)
//   - column_colour(): maps a column to its foreground colour
// ---------------------------------------------------------------------------
package vga_text_pkg;

  localparam logic [11:0] FG_CPU      = 12'h0F0;
  localparam logic [11:0] FG_INSTR    = 12'hFF0;
  localparam logic [11:0] FG_DATA     = 12'h0FF;
  localparam logic [11:0] BG          = 12'h000;
  localparam logic [11:0] GRID_COLOUR = 12'h888;

  // A cell is 4 hex digits followed by 2 blank spacing characters.
  localparam int CHARS_PER_CELL  = 6;
  localparam int DIGITS_PER_CELL = 4;
  localparam int GLYPH_SIZE      = 8;

  typedef enum logic [1:0] {
    COL_CPU   = 2'd0,
    COL_INSTR = 2'd1,
    COL_DATA  = 2'd2
  } column_t;

  function automatic logic [11:0] column_colour(input column_t col);
    case (col)
      COL_CPU:   return FG_CPU;
      COL_INSTR: return FG_INSTR;
      COL_DATA:  return FG_DATA;
      default:   return BG;
    endcase
  endfunction

endpackage

// File: rtl/hex_font_rom.sv
// ---------------------------------------------------------------------------
// hex_font_rom
// 16-glyph (0-F) 8x8 font with a registered read port.
// Ports:
//   clock_in   in   pixel clock
//   reset_in   in   asynchronous active-high reset (clears the output byte)
//   nibble_in  in   [3:0] glyph select
//   row_in     in   [2:0] glyph row
//   byte_out   out  [7:0] glyph row bits, bit 7 = leftmost pixel; valid one
//                   clock after nibble_in/row_in
// ---------------------------------------------------------------------------
module hex_font_rom (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic [3:0] nibble_in,
  input  logic [2:0] row_in,
  output logic [7:0] byte_out
);

  logic [63:0] glyph_s;
  logic [7:0]  byte_d;
  logic [7:0]  byte_q;

  // Glyph lookup: each glyph packs its 8 rows top row first (bits 63:56).
  always_comb begin
    glyph_s = 64'h0;
    case (nibble_in)
      4'h0:    glyph_s = 64'h3C666E7666663C00;
      4'h1:    glyph_s = 64'h1838181818187E00;
      4'h2:    glyph_s = 64'h3C66060C30607E00;
      4'h3:    glyph_s = 64'h3C66061C06663C00;
      4'h4:    glyph_s = 64'h0C1C3C6C7E0C0C00;
      4'h5:    glyph_s = 64'h7E607C0606663C00;
      4'h6:    glyph_s = 64'h3C60607C66663C00;
      4'h7:    glyph_s = 64'h7E060C1830303000;
      4'h8:    glyph_s = 64'h3C66663C66663C00;
      4'h9:    glyph_s = 64'h3C66663E060C3800;
      4'hA:    glyph_s = 64'h183C66667E666600;
      4'hB:    glyph_s = 64'h7C66667C66667C00;
      4'hC:    glyph_s = 64'h3C66606060663C00;
      4'hD:    glyph_s = 64'h786C6666666C7800;
      4'hE:    glyph_s = 64'h7E60607C60607E00;
      4'hF:    glyph_s = 64'h7E60607C60606000;
      default: glyph_s = 64'h0;
    endcase
    byte_d = glyph_s[8*(3'd7 - row_in) +: 8];
  end

  // Registered read port.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      byte_q <= 8'h00;
    end else begin
      byte_q <= byte_d;
    end
  end

  assign byte_out = byte_q;

endmodule

// File: rtl/hex_text_renderer.sv
// ---------------------------------------------------------------------------
// hex_text_renderer
// Draws the 30-word auxiliary buffer (CPU[0..9], instruction window[10..19],
// data window[20..29]) as 4-digit hex words in a 3-column x ELEMENTS-row
// text window, fetching words through a synchronous read port in step with
// the VGA scan. Pixel, sync and video-on outputs share a 4-cycle latency.
//
// Optional feature: define GRID_EN to draw a grey (12'h888) frame and column
// separators inside the window; without it no grid logic is built.
//
// Ports:
//   clock_in          in   pixel clock
//   reset_in          in   asynchronous active-high reset
//   h_count_in        in   [COUNT_WIDTH-1:0] current pixel column
//   v_count_in        in   [COUNT_WIDTH-1:0] current line
//   video_on_in       in   active-video flag
//   h_sync_in         in   raw horizontal sync
//   v_sync_in         in   raw vertical sync
//   aux_data_in       in   [DATA_WIDTH-1:0] buffer read data, valid one clock
//                          after aux_raddress_out
//   aux_raddress_out  out  [AUX_ADDRESS_WIDTH-1:0] buffer read address
//   rgb_out           out  [11:0] pixel colour {R4,G4,B4}
//   h_sync_out        out  h_sync_in delayed 4 clocks
//   v_sync_out        out  v_sync_in delayed 4 clocks
//   video_on_out      out  video_on_in delayed 4 clocks
// ---------------------------------------------------------------------------
module hex_text_renderer
  import vga_text_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,   // nibble selection assumes 16
  parameter int AUX_ADDRESS_WIDTH = 5,
  parameter int COUNT_WIDTH       = 10,
  parameter int ELEMENTS          = 10,
  parameter int SCALE_SHIFT       = 1,
  parameter int ORIGIN_X          = 176,
  parameter int ORIGIN_Y          = 160
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  input  logic [COUNT_WIDTH-1:0]       h_count_in,
  input  logic [COUNT_WIDTH-1:0]       v_count_in,
  input  logic                         video_on_in,
  input  logic                         h_sync_in,
  input  logic                         v_sync_in,
  input  logic [DATA_WIDTH-1:0]        aux_data_in,
  output logic [AUX_ADDRESS_WIDTH-1:0] aux_raddress_out,
  output logic [11:0]                  rgb_out,
  output logic                         h_sync_out,
  output logic                         v_sync_out,
  output logic                         video_on_out
);

  localparam int CW      = GLYPH_SIZE << SCALE_SHIFT;    // character pitch in px
  localparam int CELL_PX = CHARS_PER_CELL * CW;          // one column's width
  localparam int CX_W    = COUNT_WIDTH - 3 - SCALE_SHIFT; // char index width
  localparam int ROW_W   = $clog2(ELEMENTS);
  localparam logic [COUNT_WIDTH-1:0] X_LO  = COUNT_WIDTH'(ORIGIN_X);
  localparam logic [COUNT_WIDTH-1:0] Y_LO  = COUNT_WIDTH'(ORIGIN_Y);
  localparam logic [COUNT_WIDTH-1:0] WIN_W = COUNT_WIDTH'(3 * CELL_PX);
  localparam logic [COUNT_WIDTH-1:0] WIN_H = COUNT_WIDTH'(ELEMENTS * CW);

  // ---- E1 combinational decode ----
  logic [COUNT_WIDTH-1:0]       rel_x_s;
  logic [COUNT_WIDTH-1:0]       rel_y_s;
  logic                         in_win_s;
  logic [CX_W-1:0]              char_x_s;
  logic [CX_W-1:0]              char_base_s;
  logic [CX_W-1:0]              cell_char_s;
  logic [ROW_W-1:0]             row_s;
  column_t                      col_s;
  logic [AUX_ADDRESS_WIDTH-1:0] addr_base_s;

  // ---- pipeline registers ----
  logic [AUX_ADDRESS_WIDTH-1:0] aux_raddress_d, aux_raddress_q;
  logic                         in_win1_d, in_win1_q, in_win2_d, in_win2_q, in_win3_d, in_win3_q;
  column_t                      col1_d, col1_q, col2_d, col2_q, col3_d, col3_q;
  logic [1:0]                   digit1_d, digit1_q, digit2_d, digit2_q;
  logic                         is_digit1_d, is_digit1_q, is_digit2_d, is_digit2_q;
  logic                         is_digit3_d, is_digit3_q;
  logic [2:0]                   gx1_d, gx1_q, gx2_d, gx2_q, gx3_d, gx3_q;
  logic [2:0]                   gy1_d, gy1_q, gy2_d, gy2_q;
  logic [11:0]                  rgb_d, rgb_q;
  logic [3:0]                   hs_pipe_d, hs_pipe_q;
  logic [3:0]                   vs_pipe_d, vs_pipe_q;
  logic [3:0]                   von_pipe_d, von_pipe_q;

  logic [3:0] nibble_s;
  logic [7:0] font_byte_s;
  logic       glyph_bit_s;

`ifdef GRID_EN
  logic       grid_s;
  logic [2:0] grid_pipe_d, grid_pipe_q;
`endif

  // Scan position -> window membership, column, cell character, row and address.
  always_comb begin
    rel_x_s  = h_count_in - X_LO;
    rel_y_s  = v_count_in - Y_LO;
    // The lower-bound compares keep the wrapped (negative) offsets outside.
    in_win_s = (h_count_in >= X_LO) && (rel_x_s < WIN_W) &&
               (v_count_in >= Y_LO) && (rel_y_s < WIN_H);
    char_x_s = rel_x_s[COUNT_WIDTH-1 -: CX_W];
    row_s    = rel_y_s[3+SCALE_SHIFT +: ROW_W];
    // Column chosen by compare against the cell boundaries, no divider.
    if (char_x_s < CX_W'(CHARS_PER_CELL)) begin
      col_s       = COL_CPU;
      char_base_s = CX_W'(0);
      addr_base_s = AUX_ADDRESS_WIDTH'(0);
    end else if (char_x_s < CX_W'(2 * CHARS_PER_CELL)) begin
      col_s       = COL_INSTR;
      char_base_s = CX_W'(CHARS_PER_CELL);
      addr_base_s = AUX_ADDRESS_WIDTH'(ELEMENTS);
    end else begin
      col_s       = COL_DATA;
      char_base_s = CX_W'(2 * CHARS_PER_CELL);
      addr_base_s = AUX_ADDRESS_WIDTH'(2 * ELEMENTS);
    end
    cell_char_s = char_x_s - char_base_s;
  end

`ifdef GRID_EN
  // Frame and column separator pixels inside the window.
  always_comb begin
    grid_s = in_win_s &&
             ((rel_x_s == COUNT_WIDTH'(0)) ||
              (rel_x_s == COUNT_WIDTH'(CELL_PX)) ||
              (rel_x_s == COUNT_WIDTH'(2 * CELL_PX)) ||
              (rel_x_s == COUNT_WIDTH'(3 * CELL_PX - 1)) ||
              (rel_y_s == COUNT_WIDTH'(0)) ||
              (rel_y_s == COUNT_WIDTH'(ELEMENTS * CW - 1)));
    grid_pipe_d = {grid_pipe_q[1:0], grid_s};
  end
`endif

  // The buffer's read register acts as the E2 data stage, so the nibble is
  // picked combinationally from aux_data_in using the E2 digit index.
  always_comb begin
    case (digit2_q)
      2'd0:    nibble_s = aux_data_in[15:12];
      2'd1:    nibble_s = aux_data_in[11:8];
      2'd2:    nibble_s = aux_data_in[7:4];
      2'd3:    nibble_s = aux_data_in[3:0];
      default: nibble_s = 4'h0;
    endcase
  end

  hex_font_rom u_font (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .nibble_in (nibble_s),
    .row_in    (gy2_q),
    .byte_out  (font_byte_s)
  );

  // Next-state for all pipeline stages and the output colour.
  always_comb begin
    // E1
    if (in_win_s) begin
      aux_raddress_d = addr_base_s + AUX_ADDRESS_WIDTH'(row_s);
    end else begin
      aux_raddress_d = {AUX_ADDRESS_WIDTH{1'b0}};
    end
    in_win1_d   = in_win_s;
    col1_d      = col_s;
    digit1_d    = cell_char_s[1:0];
    is_digit1_d = (cell_char_s < CX_W'(DIGITS_PER_CELL));
    gx1_d       = rel_x_s[SCALE_SHIFT +: 3];
    gy1_d       = rel_y_s[SCALE_SHIFT +: 3];
    // E2
    in_win2_d   = in_win1_q;
    col2_d      = col1_q;
    digit2_d    = digit1_q;
    is_digit2_d = is_digit1_q;
    gx2_d       = gx1_q;
    gy2_d       = gy1_q;
    // E3 (font byte registered inside the ROM)
    in_win3_d   = in_win2_q;
    col3_d      = col2_q;
    is_digit3_d = is_digit2_q;
    gx3_d       = gx2_q;
    // Sync and video-on delay lines
    hs_pipe_d   = {hs_pipe_q[2:0], h_sync_in};
    vs_pipe_d   = {vs_pipe_q[2:0], v_sync_in};
    von_pipe_d  = {von_pipe_q[2:0], video_on_in};
    // E4: video_on stage 2 is the flag that shifts out alongside this pixel.
    glyph_bit_s = font_byte_s[3'd7 - gx3_q];
    if (!von_pipe_q[2]) begin
      rgb_d = 12'h000;
`ifdef GRID_EN
    end else if (grid_pipe_q[2]) begin
      rgb_d = GRID_COLOUR;
`endif
    end else if (in_win3_q && is_digit3_q && glyph_bit_s) begin
      rgb_d = column_colour(col3_q);
    end else begin
      rgb_d = BG;
    end
  end

  // Pipeline registers; sync lines reset high so no false sync pulse follows reset.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      aux_raddress_q <= {AUX_ADDRESS_WIDTH{1'b0}};
      in_win1_q      <= 1'b0;
      in_win2_q      <= 1'b0;
      in_win3_q      <= 1'b0;
      col1_q         <= COL_CPU;
      col2_q         <= COL_CPU;
      col3_q         <= COL_CPU;
      digit1_q       <= 2'd0;
      digit2_q       <= 2'd0;
      is_digit1_q    <= 1'b0;
      is_digit2_q    <= 1'b0;
      is_digit3_q    <= 1'b0;
      gx1_q          <= 3'd0;
      gx2_q          <= 3'd0;
      gx3_q          <= 3'd0;
      gy1_q          <= 3'd0;
      gy2_q          <= 3'd0;
      rgb_q          <= 12'h000;
      hs_pipe_q      <= 4'hF;
      vs_pipe_q      <= 4'hF;
      von_pipe_q     <= 4'h0;
`ifdef GRID_EN
      grid_pipe_q    <= 3'd0;
`endif
    end else begin
      aux_raddress_q <= aux_raddress_d;
      in_win1_q      <= in_win1_d;
      in_win2_q      <= in_win2_d;
      in_win3_q      <= in_win3_d;
      col1_q         <= col1_d;
      col2_q         <= col2_d;
      col3_q         <= col3_d;
      digit1_q       <= digit1_d;
      digit2_q       <= digit2_d;
      is_digit1_q    <= is_digit1_d;
      is_digit2_q    <= is_digit2_d;
      is_digit3_q    <= is_digit3_d;
      gx1_q          <= gx1_d;
      gx2_q          <= gx2_d;
      gx3_q          <= gx3_d;
      gy1_q          <= gy1_d;
      gy2_q          <= gy2_d;
      rgb_q          <= rgb_d;
      hs_pipe_q      <= hs_pipe_d;
      vs_pipe_q      <= vs_pipe_d;
      von_pipe_q     <= von_pipe_d;
`ifdef GRID_EN
      grid_pipe_q    <= grid_pipe_d;
`endif
    end
  end

  assign aux_raddress_out = aux_raddress_q;
  assign rgb_out          = rgb_q;
  assign h_sync_out       = hs_pipe_q[3];
  assign v_sync_out       = vs_pipe_q[3];
  assign video_on_out     = von_pipe_q[3];

endmodule
